// File: rtl/core_seq_if.sv
// Sequencer-to-datapath/bus signal bundle for core_seq.
// master is the sequencer side, slave is the datapath and bus side.
interface core_seq_if;
    logic        seq_i_run;
    logic        seq_o_imem_req;
    logic        seq_i_imem_ack;
    logic        seq_o_inst_we;
    logic        seq_i_is_load;
    logic        seq_i_is_store;
    logic        seq_o_dmem_req;
    logic        seq_o_dmem_we;
    logic        seq_i_dmem_ack;
    logic        seq_o_rf_we_en;
    logic        seq_o_pc_we;
    logic        seq_o_fault;
    logic        seq_i_fault_clr;
    logic [2:0]  seq_o_state;
    logic [31:0] seq_o_retire_cnt;

    modport master (
        input  seq_i_run, seq_i_imem_ack, seq_i_is_load, seq_i_is_store,
               seq_i_dmem_ack, seq_i_fault_clr,
        output seq_o_imem_req, seq_o_inst_we, seq_o_dmem_req, seq_o_dmem_we,
               seq_o_rf_we_en, seq_o_pc_we, seq_o_fault, seq_o_state,
               seq_o_retire_cnt
    );

    modport slave (
        output seq_i_run, seq_i_imem_ack, seq_i_is_load, seq_i_is_store,
               seq_i_dmem_ack, seq_i_fault_clr,
        input  seq_o_imem_req, seq_o_inst_we, seq_o_dmem_req, seq_o_dmem_we,
               seq_o_rf_we_en, seq_o_pc_we, seq_o_fault, seq_o_state,
               seq_o_retire_cnt
    );
endinterface

// File: rtl/core_seq.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with bus handshakes,
// bus-timeout fault and retired-instruction counter.
module core_seq #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    core_seq_if.master  bus
);
    localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    state_t        state, nxt;
    logic [WW-1:0] wait_cnt;
    logic          mem_is_store;
    logic          imem_req, dmem_req, dmem_we, rf_we_en, pc_we, fault;
    logic [31:0]   retire_cnt;
    logic          tmo;

    // A zero TIMEOUT never faults; the counter still runs but is ignored.
    assign tmo = (TIMEOUT != 0) && (wait_cnt == WW'(TIMEOUT));

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (bus.seq_i_run) nxt = S_FETCH;
            S_FETCH:   if (bus.seq_i_imem_ack) nxt = S_DECODE;
                       else if (tmo)           nxt = S_FAULT;
            S_DECODE:  nxt = S_EXECUTE;
            S_EXECUTE: nxt = (bus.seq_i_is_load || bus.seq_i_is_store) ? S_MEM : S_WB;
            S_MEM:     if (bus.seq_i_dmem_ack) nxt = S_WB;
                       else if (tmo)           nxt = S_FAULT;
            S_WB:      nxt = bus.seq_i_run ? S_FETCH : S_IDLE;
            S_FAULT:   if (bus.seq_i_fault_clr) nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            mem_is_store <= 1'b0;
            retire_cnt   <= 32'd0;
            imem_req     <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            rf_we_en     <= 1'b0;
            pc_we        <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state <= nxt;
            if ((state == S_FETCH && nxt == S_FETCH) || (state == S_MEM && nxt == S_MEM))
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (state == S_EXECUTE) mem_is_store <= bus.seq_i_is_store;
            if (state == S_WB)      retire_cnt   <= retire_cnt + 32'd1;
            imem_req <= (nxt == S_FETCH);
            dmem_req <= (nxt == S_MEM);
            dmem_we  <= (nxt == S_MEM) &&
                        ((state == S_EXECUTE) ? bus.seq_i_is_store : mem_is_store);
            rf_we_en <= (nxt == S_WB);
            pc_we    <= (nxt == S_WB);
            fault    <= (nxt == S_FAULT);
        end
    end

    assign bus.seq_o_imem_req   = imem_req;
    assign bus.seq_o_inst_we    = (state == S_FETCH) && bus.seq_i_imem_ack;
    assign bus.seq_o_dmem_req   = dmem_req;
    assign bus.seq_o_dmem_we    = dmem_we;
    assign bus.seq_o_rf_we_en   = rf_we_en;
    assign bus.seq_o_pc_we      = pc_we;
    assign bus.seq_o_fault      = fault;
    assign bus.seq_o_state      = state;
    assign bus.seq_o_retire_cnt = retire_cnt;
endmodule
